bcd_seven_seg_scanner: RTL and testbench
========================================

// Module: bcd_seven_seg_scanner
// PURPOSE
//  Downstream consumer of the packed BCD produced by the binary-to-BCD converter. Latches a 3-digit
//  packed BCD word and time-multiplexes it onto one shared active-low 7-segment bus (common-anode display).
//  Ghost-free digit scanning, frame-synchronous updates (no tearing), invalid-digit flagging.
// PARAMETERS
//  REFRESH_DIV   4096  cycles each digit is driven per slot (>=1)
//  BLANK_CYCLES  16    cycles all anodes off before each digit slot, anti-ghosting (>=1)
// PORTS
//  clk         in   1   single clock domain
//  rst_n       in   1   asynchronous active-low reset
//  bcd_in      in   12  packed BCD {hundreds,tens,ones}
//  bcd_valid   in   1   1-cycle qualifier; bcd_in captured when high; no backpressure
//  seg_n       out  7   {g,f,e,d,c,b,a}, active low
//  an_n        out  3   digit enables, active low; [0]=ones,[1]=tens,[2]=hundreds
//  frame_tick  out  1   1-cycle pulse at each frame start (display register update)
//  bcd_err     out  1   high while the displayed word has any nibble > 9
// BEHAVIOUR
//  Reset: seg_n=7'h7F, an_n=3'b111, frame_tick=0, bcd_err=0; pending/display regs=0; digit idx=0; state BLANK.
//  Regs: pending (written on every bcd_valid, last write wins), display (drives the outputs).
//  FSM per slot: BLANK (BLANK_CYCLES cycles, an_n=111, seg_n=7F) -> DRIVE (REFRESH_DIV cycles, one an_n bit low)
//    -> next slot. Slot order ones->tens->hundreds->ones; idx wraps 2->0. Frame = 3*(BLANK_CYCLES+REFRESH_DIV) cycles.
//  seg_n/an_n are registered and change only at state edges; an_n never has >1 bit low; an_n low only in DRIVE.
//  Frame start = entry to BLANK of slot 0: display<=pending, frame_tick high that one cycle.
//    The first BLANK after reset is not a frame start (no tick; display stays 0).
//  bcd_valid on the frame-start edge: bcd_in bypasses to display directly (and also to pending).
//  Latency: a word is shown from the next frame start; worst case one full frame + 1 cycle.
//  Decode: 0-9 standard glyphs (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000); nibble > 9 shows dash (7'b0111111).
//  bcd_err registered from display; updates on the same edge as display.
//  Counter width $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1); terminal count compare, no overflow.
//  Async reset mid-frame: all outputs go to reset values immediately; scanning restarts at slot 0 BLANK.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: hundreds slot blank if hundreds==0; tens slot blank if hundreds==0 && tens==0;
//    ones never blanked. A blanked slot keeps full timing with an_n=111 and seg_n=7F.
//  Undefined: all three digits always shown, including leading zeros.
// STRUCTURE
//  Package bcd_display_pkg: FSM state encoding, NUM_DIGITS=3, SEG_BLANK/SEG_DASH, 0-9 glyph constants.
//  Sub-module bcd_to_seg7: combinational nibble -> active-low segments (dash for > 9).
//  Top: pending/display regs, slot counter, digit index, FSM, registered outputs.
// TESTING  (REFRESH_DIV=4, BLANK_CYCLES=2, frame=18 cycles)
//  Reset: hold rst_n=0 -> seg_n=7F, an_n=111, frame_tick=0; release -> 2 blank cycles, then an_n=110 for 4 cycles.
//  bcd_valid with bcd_in=12'h128 -> at the next frame start: frame_tick pulse; slots show ones 8 (seg_n 0000000),
//    tens 2, hundreds 1 (1111001); an_n sequence 110,111,101,111,011.
//  Two bcd_valid pulses in one frame (12'h111, then 12'h345) -> only 345 appears; bcd_valid on the frame-start
//    cycle -> that word is shown in the same frame.
//  bcd_in=12'h1A3 -> tens slot shows dash 0111111; bcd_err=1 from frame start until a valid word is loaded.
//  12'h007: with LEADING_ZERO_BLANK_EN, hundreds/tens slots keep an_n=111 and only ones is lit;
//    without it, 0,0,7 are lit.
//  Assert rst_n low during a tens DRIVE slot -> outputs reset asynchronously; after release the display shows 000
//    until the next load + frame start.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared FSM encoding, digit count and active-low 7-segment glyphs {g,f,e,d,c,b,a}
package bcd_display_pkg;
  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;
  localparam int NUM_DIGITS = 3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [9:0][6:0] SEG_DIGITS = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                            SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  function automatic logic bcd_invalid(input logic [11:0] w);
    return (w[3:0] > 4'd9) || (w[7:4] > 4'd9) || (w[11:8] > 4'd9);
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low segments, dash for non-decimal codes
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);
  always_comb seg_n = (bcd > 4'd9) ? SEG_DASH : SEG_DIGITS[bcd];
endmodule

// File: rtl/bcd_seven_seg_scanner.sv
// bcd_seven_seg_scanner: frame-synchronous 3-digit multiplexed common-anode 7-segment driver.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros in the hundreds/tens slots.
module bcd_seven_seg_scanner
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 4096,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n,
  output logic        frame_tick,
  output logic        bcd_err
);
  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CNT + 1);
  scan_state_t state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_nxt;
  logic [11:0]   pending, display, frame_word;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [2:0]    an_sel;
  logic          last_slot, blank_slot;
  bcd_to_seg7 u_dec (.bcd(nib), .seg_n(dec_seg));
  always_comb begin
    nib        = display[{idx, 2'b00} +: 4];
    last_slot  = idx == 2'(NUM_DIGITS - 1);
    idx_nxt    = last_slot ? 2'd0 : idx + 2'd1;
    an_sel     = ~(3'b001 << idx);
    frame_word = bcd_valid ? bcd_in : pending;
`ifdef LEADING_ZERO_BLANK_EN
    blank_slot = (idx == 2'd2 && display[11:8] == 4'd0) || (idx == 2'd1 && display[11:4] == 8'd0);
`else
    blank_slot = 1'b0;
`endif
  end
  // A frame starts when the hundreds DRIVE slot ends; the post-reset BLANK therefore never ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      pending    <= '0;
      display    <= '0;
      seg_n      <= SEG_BLANK;
      an_n       <= 3'b111;
      frame_tick <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (bcd_valid) pending <= bcd_in;
      if (state == ST_BLANK) begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state <= ST_DRIVE;
          cnt   <= '0;
          an_n  <= blank_slot ? 3'b111 : an_sel;
          seg_n <= blank_slot ? SEG_BLANK : dec_seg;
        end else cnt <= cnt + 1'b1;
      end else if (cnt == CW'(REFRESH_DIV - 1)) begin
        state <= ST_BLANK;
        cnt   <= '0;
        idx   <= idx_nxt;
        an_n  <= 3'b111;
        seg_n <= SEG_BLANK;
        if (last_slot) begin
          display    <= frame_word;
          bcd_err    <= bcd_invalid(frame_word);
          frame_tick <= 1'b1;
        end
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// tb_bcd_seven_seg_scanner: directed scoreboard bench, REFRESH_DIV=4, BLANK_CYCLES=2 (18-cycle frame)
module tb_bcd_seven_seg_scanner;
  localparam int RD = 4, BC = 2;
  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
  } slot_t;
  logic clk = 1'b0, rst_n = 1'b0, bcd_valid = 1'b0;
  logic [11:0] bcd_in = '0;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic frame_tick, bcd_err;
  int total = 0, bad = 0;
  slot_t exp_q[$];
  logic err_q[$];
  bcd_seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick), .bcd_err(bcd_err));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction
  function automatic slot_t exp_slot(input logic [11:0] w, input int s);
    logic [3:0] d;
    logic blank;
    d = w[s*4 +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (s == 2 && w[11:8] == 4'd0) || (s == 1 && w[11:4] == 8'd0);
`endif
    if (blank) return '{an: 3'b111, seg: 7'h7F};
    return '{an: (s == 0) ? 3'b110 : (s == 1) ? 3'b101 : 3'b011, seg: glyph(d)};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push_word(input logic [11:0] w);
    for (int s = 0; s < 3; s++) exp_q.push_back(exp_slot(w, s));
    err_q.push_back((w[3:0] > 4'd9) || (w[7:4] > 4'd9) || (w[11:8] > 4'd9));
  endtask
  task automatic drive(input logic [11:0] w, input bit show);
    bcd_in = w;
    bcd_valid = 1'b1;
    if (show) push_word(w);
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask
  task automatic reset_start();
    chk("rel_an0", 16'(an_n), 16'(3'b111));
    chk("rel_tick0", 16'(frame_tick), 16'd0);
    @(negedge clk);
    chk("rel_an1", 16'(an_n), 16'(3'b111));
    chk("rel_tick1", 16'(frame_tick), 16'd0);
    repeat (RD) begin
      @(negedge clk);
      chk("rel_drive_an", 16'(an_n), 16'(3'b110));
      chk("rel_drive_seg", 16'(seg_n), 16'(7'b1000000));
    end
  endtask
  task automatic run_frame();
    int n;
    slot_t es;
    logic e;
    n = 0;
    while (!frame_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick", 16'(frame_tick), 16'd1);
    if (!frame_tick) return;
    if (exp_q.size() < 3 || err_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=%0d exp=3", exp_q.size());
      return;
    end
    e = err_q.pop_front();
    for (int s = 0; s < 3; s++) begin
      repeat (BC) begin
        chk("blank_an", 16'(an_n), 16'(3'b111));
        chk("blank_seg", 16'(seg_n), 16'(7'h7F));
        chk("bcd_err", 16'(bcd_err), 16'(e));
        @(negedge clk);
      end
      es = exp_q.pop_front();
      repeat (RD) begin
        chk("drive_an", 16'(an_n), 16'(es.an));
        chk("drive_seg", 16'(seg_n), 16'(es.seg));
        chk("drive_tick", 16'(frame_tick), 16'd0);
        @(negedge clk);
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg", 16'(seg_n), 16'(7'h7F));
    chk("rst_an", 16'(an_n), 16'(3'b111));
    chk("rst_tick", 16'(frame_tick), 16'd0);
    chk("rst_err", 16'(bcd_err), 16'd0);
    rst_n = 1'b1;
    reset_start();
    drive(12'h128, 1'b1);
    run_frame();
    drive(12'h111, 1'b0);
    drive(12'h345, 1'b1);
    run_frame();
    drive(12'h999, 1'b0);
    repeat (16) @(negedge clk);
    drive(12'h456, 1'b1);
    run_frame();
    drive(12'h1A3, 1'b1);
    run_frame();
    drive(12'h042, 1'b1);
    chk("err_held", 16'(bcd_err), 16'd1);
    run_frame();
    drive(12'h007, 1'b1);
    run_frame();
    drive(12'h555, 1'b1);
    run_frame();
    repeat (9) @(negedge clk);
    chk("pre_rst_an", 16'(an_n), 16'(3'b101));
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", 16'(seg_n), 16'(7'h7F));
    chk("async_an", 16'(an_n), 16'(3'b111));
    chk("async_tick", 16'(frame_tick), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_start();
    push_word(12'h000);
    run_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
